tmu_divseq: RTL

- Time-multiplexed edge-division sequencer for the TMU.
- Accepts one triangle's nine edge divisions (dx/du/dv × edges 1..3) on the pipeline handshake and runs them serially through a single external tmu_divider11 instance.
- Collects quotients and remainders, then presents the full set downstream.
- Area-reduced replacement for the nine-divider edge-division stage; same upstream and downstream handshake.

---
 rtl/tmu_divseq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/tmu_divseq.sv
// Purpose: time-multiplexed edge-division sequencer; runs one triangle's nine
//          edge divisions serially through a single external tmu_divider11.
// Latency: accept + 1 + sum over jobs of (1 if divisor==0 else D+2) to DONE,
//          where D is the number of cycles the divider holds ready low.
// Backpressure: pipe_ack_o only in IDLE; results held stable in DONE until pipe_ack_i.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   busy                    high whenever a triangle is in flight or waiting downstream
//   pipe_stb_i/pipe_ack_o   upstream handshake (ack is combinational, IDLE only)
//   dividends/divisors      job k operand at [k*DW +: DW]; job k uses edge k%3
//   positive_i              per-job sign flags, passed through
//   pipe_stb_o/pipe_ack_i   downstream handshake (stb is combinational, DONE only)
//   quotients/remainders    registered results, same packing as dividends
//   positive_o/divisors_o   latched sign flags and divisors
//   div_*                   interface to the shared divider (start, operands, ready, results)

module tmu_divseq #(
  parameter int DW = 11
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  output logic            busy,

  input  logic            pipe_stb_i,
  output logic            pipe_ack_o,
  input  logic [9*DW-1:0] dividends,
  input  logic [3*DW-1:0] divisors,
  input  logic [8:0]      positive_i,

  output logic            pipe_stb_o,
  input  logic            pipe_ack_i,
  output logic [9*DW-1:0] quotients,
  output logic [9*DW-1:0] remainders,
  output logic [8:0]      positive_o,
  output logic [3*DW-1:0] divisors_o,

  output logic            div_start,
  output logic [DW-1:0]   div_dividend,
  output logic [DW-1:0]   div_divisor,
  input  logic            div_ready,
  input  logic [DW-1:0]   div_quotient,
  input  logic [DW-1:0]   div_remainder
);

  localparam int NJOB  = 9;
  localparam int NEDGE = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    job_q, job_d;
  logic [3:0]    job_nx;
  logic          last_job;
  logic          advance;

  // Latched triangle operands; upstream is free to change after accept.
  logic [DW-1:0] dvd_q [NJOB];
  logic [DW-1:0] dvd_d [NJOB];
  logic [DW-1:0] dvs_q [NEDGE];
  logic [DW-1:0] dvs_d [NEDGE];
  logic [8:0]    pos_q, pos_d;

  // Result slots, written only when a job completes.
  logic [DW-1:0] quo_q [NJOB];
  logic [DW-1:0] quo_d [NJOB];
  logic [DW-1:0] rem_q [NJOB];
  logic [DW-1:0] rem_d [NJOB];

  // Divider operand registers. They are loaded with the operands of the job
  // about to enter ISSUE, so in ISSUE they already hold the current job's
  // operands: the start pulse and its operands are presented together, and
  // the divisor register doubles as the zero-divisor bypass test.
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;

  // Edge selector: jobs are ordered dx1,dx2,dx3,du1,...; edge = job mod 3.
  function automatic logic [1:0] edge_of(input logic [3:0] j);
    case (j)
      4'd0, 4'd3, 4'd6: edge_of = 2'd0;
      4'd1, 4'd4, 4'd7: edge_of = 2'd1;
      default:          edge_of = 2'd2;
    endcase
  endfunction

  assign job_nx   = job_q + 4'd1;
  assign last_job = (job_q == 4'd8);

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    pos_d     = pos_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    div_start = 1'b0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pipe_stb_i) begin
          for (int k = 0; k < NJOB; k++) begin
            dvd_d[k] = dividends[k*DW +: DW];
          end
          for (int e = 0; e < NEDGE; e++) begin
            dvs_d[e] = divisors[e*DW +: DW];
          end
          pos_d   = positive_i;
          job_d   = 4'd0;
          // Job 0 operands come straight from the ports, the latches are
          // being written in this same cycle.
          opa_d   = dividends[DW-1:0];
          opb_d   = divisors[DW-1:0];
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (opb_q == '0) begin
          // Zero divisor never reaches the divider: q=0, r=dividend.
          quo_d[job_q] = '0;
          rem_d[job_q] = opa_q;
          advance      = 1'b1;
        end else if (div_ready) begin
          div_start = 1'b1;
          state_d   = S_ARM;
        end
      end

      // The divider drops ready one edge after start, so ready seen here may
      // still be the stale idle indication; skip one cycle before watching it.
      S_ARM: state_d = S_WAIT;

      S_WAIT: begin
        if (div_ready) begin
          quo_d[job_q] = div_quotient;
          rem_d[job_q] = div_remainder;
          advance      = 1'b1;
        end
      end

      S_DONE: begin
        if (pipe_ack_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (last_job) begin
        state_d = S_DONE;
      end else begin
        job_d   = job_nx;
        opa_d   = dvd_q[job_nx];
        opb_d   = dvs_q[edge_of(job_nx)];
        state_d = S_ISSUE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      job_q   <= 4'd0;
      pos_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      for (int k = 0; k < NJOB; k++) begin
        dvd_q[k] <= '0;
        quo_q[k] <= '0;
        rem_q[k] <= '0;
      end
      for (int e = 0; e < NEDGE; e++) begin
        dvs_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      pos_q   <= pos_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign pipe_ack_o   = (state_q == S_IDLE);
  assign pipe_stb_o   = (state_q == S_DONE);
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;
  assign positive_o   = pos_q;

  for (genvar g = 0; g < NJOB; g++) begin : g_pack_res
    assign quotients[g*DW +: DW]  = quo_q[g];
    assign remainders[g*DW +: DW] = rem_q[g];
  end

  for (genvar g = 0; g < NEDGE; g++) begin : g_pack_dvs
    assign divisors_o[g*DW +: DW] = dvs_q[g];
  end

endmodule
